// File: rtl/flash_read_responder.sv
// Avalon-MM read-only word server standing in for the flash controller.
// Internal word memory preloaded through a load port; each held read sees a
// fixed waitrequest stall, then data returns READ_LATENCY cycles after accept.
module flash_read_responder #(
    parameter int ADDR_W       = 23,
    parameter int DATA_W       = 32,
    parameter int MEM_AW       = 8,
    parameter int WAIT_CYCLES  = 2,
    parameter int READ_LATENCY = 3,
    parameter int MAX_PENDING  = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              read,
    input  logic [ADDR_W-1:0] address,
    output logic              waitrequest,
    output logic [DATA_W-1:0] readdata,
    output logic              readdatavalid,
    input  logic              load_en,
    input  logic [MEM_AW-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic              oob_err,
    input  logic              oob_clr,
    output logic [15:0]       accept_count
);

    // A zero-cycle stall still needs a 1-bit counter to keep the compare legal.
    localparam int SC_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam int PC_W = $clog2(MAX_PENDING + 1);
    localparam logic [SC_W-1:0] STALL_MAX = SC_W'(WAIT_CYCLES);
    localparam logic [PC_W-1:0] PEND_MAX  = PC_W'(MAX_PENDING);

    logic [DATA_W-1:0]       mem_q [2**MEM_AW];

    logic [SC_W-1:0]         stall_cnt_q, stall_cnt_d;
    logic [PC_W-1:0]         pending_q, pending_d;
    logic [READ_LATENCY-1:0] vld_q, vld_d;
    logic [DATA_W-1:0]       dat_q [READ_LATENCY];
    logic [DATA_W-1:0]       dat_d [READ_LATENCY];
    logic                    oob_q, oob_d;
    logic [15:0]             cnt_q, cnt_d;

    logic                    accept;
    logic                    addr_oob;
    logic [DATA_W-1:0]       rd_word;

    // Stall decision uses only read and registered state, never the address.
    assign waitrequest = ~reset_n
                       | (read & ((stall_cnt_q != STALL_MAX) | (pending_q == PEND_MAX)));
    assign accept      = read & ~waitrequest;
    assign addr_oob    = |address[ADDR_W-1:MEM_AW];
    assign rd_word     = mem_q[address[MEM_AW-1:0]];

    assign readdatavalid = vld_q[READ_LATENCY-1];
    assign readdata      = dat_q[READ_LATENCY-1];
    assign oob_err       = oob_q;
    assign accept_count  = cnt_q;

    // Preload port; memory is not touched by reset. A same-edge accept
    // samples the old word because the read happens before this update lands.
    always_ff @(posedge clk) begin
        if (load_en) begin
            mem_q[load_addr] <= load_data;
        end
    end

    // Next-state for stall counter, pending count, latency pipe and status.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        pending_d   = pending_q;
        oob_d       = oob_q;
        cnt_d       = cnt_q;
        vld_d       = '0;

        if (!read || accept) begin
            stall_cnt_d = '0;
        end else if (stall_cnt_q != STALL_MAX) begin
            stall_cnt_d = stall_cnt_q + SC_W'(1);
        end

        if (accept && !vld_q[READ_LATENCY-1]) begin
            pending_d = pending_q + PC_W'(1);
        end else if (!accept && vld_q[READ_LATENCY-1]) begin
            pending_d = pending_q - PC_W'(1);
        end

        // Data registers only move with a valid token so the last stage holds
        // the previously returned word between valids.
        vld_d[0] = accept;
        dat_d[0] = accept ? rd_word : dat_q[0];
        for (int i = 1; i < READ_LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
            dat_d[i] = vld_q[i-1] ? dat_q[i-1] : dat_q[i];
        end

        // Set has priority over clear.
        if (accept && addr_oob) begin
            oob_d = 1'b1;
        end else if (oob_clr) begin
            oob_d = 1'b0;
        end

        cnt_d = cnt_q + 16'(accept);
    end

    // State registers; reset drops every in-flight read.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
            pending_q   <= '0;
            vld_q       <= '0;
            oob_q       <= 1'b0;
            cnt_q       <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            stall_cnt_q <= stall_cnt_d;
            pending_q   <= pending_d;
            vld_q       <= vld_d;
            oob_q       <= oob_d;
            cnt_q       <= cnt_d;
            for (int i = 0; i < READ_LATENCY; i++) begin
                dat_q[i] <= dat_d[i];
            end
        end
    end

endmodule

// File: tb/tb_flash_read_responder.sv
// Bench for flash_read_responder: two instances (default stall, and zero-stall
// with a deeper pending cap) checked every cycle against a queue-based model.
module tb_flash_read_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rd      [2];
    logic [22:0] addr    [2];
    logic        ld_en   [2];
    logic [7:0]  ld_addr [2];
    logic [31:0] ld_data [2];
    logic        clr     [2];

    logic        wr_o    [2];
    logic        rdv_o   [2];
    logic [31:0] rdata_o [2];
    logic        oob_o   [2];
    logic [15:0] cnt_o   [2];

    always #5 clk = ~clk;

    flash_read_responder #(
        .ADDR_W(23), .DATA_W(32), .MEM_AW(8),
        .WAIT_CYCLES(2), .READ_LATENCY(3), .MAX_PENDING(2)
    ) u_dut_a (
        .clk(clk), .reset_n(rst_n), .read(rd[0]), .address(addr[0]),
        .waitrequest(wr_o[0]), .readdata(rdata_o[0]), .readdatavalid(rdv_o[0]),
        .load_en(ld_en[0]), .load_addr(ld_addr[0]), .load_data(ld_data[0]),
        .oob_err(oob_o[0]), .oob_clr(clr[0]), .accept_count(cnt_o[0])
    );

    flash_read_responder #(
        .ADDR_W(23), .DATA_W(32), .MEM_AW(8),
        .WAIT_CYCLES(0), .READ_LATENCY(3), .MAX_PENDING(3)
    ) u_dut_b (
        .clk(clk), .reset_n(rst_n), .read(rd[1]), .address(addr[1]),
        .waitrequest(wr_o[1]), .readdata(rdata_o[1]), .readdatavalid(rdv_o[1]),
        .load_en(ld_en[1]), .load_addr(ld_addr[1]), .load_data(ld_data[1]),
        .oob_err(oob_o[1]), .oob_clr(clr[1]), .accept_count(cnt_o[1])
    );

    function automatic int waitp(input int k);
        return (k == 0) ? 2 : 0;
    endfunction
    function automatic int maxp(input int k);
        return (k == 0) ? 2 : 3;
    endfunction
    localparam int LAT = 3;

    // Reference model: outstanding responses as a queue of (due cycle, word).
    typedef struct {
        int          due;
        logic [31:0] data;
    } resp_t;

    resp_t       q[$];
    logic [31:0] mem_m  [2][256];
    int          held_m [2];
    logic        oob_m  [2];
    logic [15:0] cnt_m  [2];
    logic [31:0] last_m [2];

    int          sel;
    int          cyc;
    bit          chk_en;
    logic        last_obs_acc;
    int          last_acc_cyc;
    logic [31:0] seen_q[$];
    int          nvec;
    int          nerr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic pred_accept();
        return rst_n && rd[sel]
            && !((held_m[sel] < waitp(sel)) || (q.size() == maxp(sel)));
    endfunction

    // One clock cycle: check the selected instance, advance the model, clock.
    task automatic step();
        int    k;
        logic  exp_wr;
        logic  exp_rdv;
        logic  acc;
        resp_t r;
        k = sel;
        #1;
        exp_wr  = !rst_n || (rd[k] && ((held_m[k] < waitp(k)) || (q.size() == maxp(k))));
        exp_rdv = (q.size() > 0) && (q[0].due == cyc);
        if (exp_rdv) last_m[k] = q[0].data;
        if (chk_en) begin
            chk("waitrequest", wr_o[k], exp_wr);
            chk("readdatavalid", rdv_o[k], exp_rdv);
            chk("readdata", rdata_o[k], last_m[k]);
            chk("oob_err", oob_o[k], oob_m[k]);
            chk("accept_count", cnt_o[k], cnt_m[k]);
        end
        if (rdv_o[k] === 1'b1) seen_q.push_back(rdata_o[k]);
        last_obs_acc = rd[k] && (wr_o[k] === 1'b0);
        if (last_obs_acc) last_acc_cyc = cyc;
        acc = rst_n && rd[k] && !exp_wr;

        if (!rst_n) begin
            q.delete();
            for (int j = 0; j < 2; j++) begin
                held_m[j] = 0;
                oob_m[j]  = 1'b0;
                cnt_m[j]  = 16'h0;
                last_m[j] = 32'h0;
            end
        end else begin
            if (exp_rdv) void'(q.pop_front());
            if (acc) begin
                r.due  = cyc + LAT;
                r.data = mem_m[k][addr[k][7:0]];
                q.push_back(r);
                cnt_m[k] = cnt_m[k] + 16'h1;
            end
            if (acc && (addr[k][22:8] != 15'h0)) oob_m[k] = 1'b1;
            else if (clr[k]) oob_m[k] = 1'b0;
            if (!rd[k] || acc) held_m[k] = 0;
            else if (held_m[k] < waitp(k)) held_m[k] = held_m[k] + 1;
        end
        for (int j = 0; j < 2; j++) begin
            if (ld_en[j]) mem_m[j][ld_addr[j]] = ld_data[j];
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Hold a read until accepted; optional load/clear lands in the accept cycle.
    task automatic do_read(input logic [22:0] a, input logic ld, input logic [7:0] la,
                           input logic [31:0] lv, input logic clr_at, output int stalls);
        int n;
        stalls = 0;
        n = 0;
        rd[sel]   = 1'b1;
        addr[sel] = a;
        last_obs_acc = 1'b0;
        while (n < 20) begin
            if (pred_accept()) begin
                ld_en[sel]   = ld;
                ld_addr[sel] = la;
                ld_data[sel] = lv;
                clr[sel]     = clr_at;
            end
            step();
            ld_en[sel] = 1'b0;
            clr[sel]   = 1'b0;
            n++;
            if (last_obs_acc) break;
            stalls++;
        end
        rd[sel] = 1'b0;
        chk("read_accepted", last_obs_acc, 1'b1);
        repeat (LAT + 2) step();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        int acc_cyc[$];
        int n;
        logic [31:0] exp_seq [4];

        nvec = 0; nerr = 0; cyc = 0; sel = 0; chk_en = 0;
        last_obs_acc = 1'b0; last_acc_cyc = 0;
        rst_n = 1'b0;
        for (int j = 0; j < 2; j++) begin
            rd[j] = 1'b0; addr[j] = '0; ld_en[j] = 1'b0; ld_addr[j] = '0;
            ld_data[j] = '0; clr[j] = 1'b0;
            held_m[j] = 0; oob_m[j] = 1'b0; cnt_m[j] = '0; last_m[j] = '0;
        end

        // Reset state
        step();
        chk_en = 1;
        step();
        chk("reset_waitrequest", wr_o[0], 1'b1);
        chk("reset_count", cnt_o[0], 16'h0);
        rst_n = 1'b1;

        // Preload both memories with i*0x1111, then a few special words in A
        for (int i = 0; i < 256; i++) begin
            for (int j = 0; j < 2; j++) begin
                ld_en[j] = 1'b1; ld_addr[j] = 8'(i); ld_data[j] = 32'(i) * 32'h1111;
            end
            step();
        end
        ld_en[1] = 1'b0;
        ld_addr[0] = 8'd0; ld_data[0] = 32'h0BADF00D; step();
        ld_addr[0] = 8'd5; ld_data[0] = 32'hDEADBEEF; step();
        ld_addr[0] = 8'd7; ld_data[0] = 32'h00000000; step();
        ld_en[0] = 1'b0;

        // Basic held read with two stall cycles
        sel = 0;
        seen_q.delete();
        do_read(23'd5, 1'b0, 8'd0, 32'h0, 1'b0, st);
        chk("s1_stalls", st, 2);
        chk("s1_nvalid", seen_q.size(), 1);
        chk("s1_data", seen_q[0], 32'hDEADBEEF);
        chk("s1_count", cnt_o[0], 16'd1);

        // Load and accept on the same word in the same cycle
        seen_q.delete();
        do_read(23'd7, 1'b1, 8'd7, 32'hA5A5A5A5, 1'b0, st);
        chk("same_cycle_old", seen_q[0], 32'h0);
        seen_q.delete();
        do_read(23'd7, 1'b0, 8'd0, 32'h0, 1'b0, st);
        chk("same_cycle_new", seen_q[0], 32'hA5A5A5A5);

        // Out-of-range addresses and sticky flag
        seen_q.delete();
        do_read(23'h000100, 1'b0, 8'd0, 32'h0, 1'b0, st);
        chk("oob_data", seen_q[0], 32'h0BADF00D);
        chk("oob_set", oob_o[0], 1'b1);
        seen_q.delete();
        do_read(23'h000200, 1'b0, 8'd0, 32'h0, 1'b1, st);
        chk("oob_set_wins", oob_o[0], 1'b1);
        chk("oob2_data", seen_q[0], 32'h0BADF00D);
        clr[0] = 1'b1; step(); clr[0] = 1'b0;
        chk("oob_cleared", oob_o[0], 1'b0);

        // Abandoned request
        seen_q.delete();
        rd[0] = 1'b1; addr[0] = 23'd9; step(); rd[0] = 1'b0;
        repeat (8) step();
        chk("abandon_nvalid", seen_q.size(), 0);
        chk("abandon_count", cnt_o[0], 16'd5);
        do_read(23'd9, 1'b0, 8'd0, 32'h0, 1'b0, st);
        chk("abandon_next_stalls", st, 2);
        chk("abandon_next_data", seen_q[0], 32'h9999);

        // Zero-stall instance: back-to-back accepts until pending cap
        sel = 1;
        seen_q.delete();
        rd[1] = 1'b1; addr[1] = 23'd1; n = 0;
        while (acc_cyc.size() < 4 && n < 30) begin
            step();
            n++;
            if (last_obs_acc) begin
                acc_cyc.push_back(last_acc_cyc);
                addr[1] = addr[1] + 23'd1;
            end
        end
        rd[1] = 1'b0;
        repeat (6) step();
        chk("b2b_naccept", acc_cyc.size(), 4);
        chk("b2b_gap1", acc_cyc[1] - acc_cyc[0], 1);
        chk("b2b_gap2", acc_cyc[2] - acc_cyc[0], 2);
        chk("b2b_gap3", acc_cyc[3] - acc_cyc[0], 4);
        exp_seq = '{32'h1111, 32'h2222, 32'h3333, 32'h4444};
        chk("b2b_nvalid", seen_q.size(), 4);
        for (int i = 0; i < 4; i++) chk("b2b_data", seen_q[i], exp_seq[i]);

        // Reset with two reads in flight
        seen_q.delete();
        rd[1] = 1'b1; addr[1] = 23'd2; step();
        addr[1] = 23'd3; step();
        rd[1] = 1'b0; rst_n = 1'b0; step();
        chk("reset_wr_b", wr_o[1], 1'b1);
        rst_n = 1'b1;
        repeat (6) step();
        chk("reset_drop_nvalid", seen_q.size(), 0);
        chk("reset_drop_count", cnt_o[1], 16'd0);
        seen_q.delete();
        do_read(23'd4, 1'b0, 8'd0, 32'h0, 1'b0, st);
        chk("reset_mem_kept", seen_q[0], 32'h4444);
        chk("reset_new_count", cnt_o[1], 16'd1);

        // Randomized traffic on both instances
        for (int s = 0; s < 2; s++) begin
            sel = s;
            last_obs_acc = 1'b0;
            for (int c = 0; c < 1500; c++) begin
                if (rd[s] && !last_obs_acc) begin
                    if ($urandom_range(0, 7) == 0) rd[s] = 1'b0;
                end else begin
                    rd[s] = 1'($urandom_range(0, 1));
                    if ($urandom_range(0, 7) == 0) addr[s] = 23'($urandom);
                    else addr[s] = 23'($urandom_range(0, 15));
                end
                ld_en[s]   = ($urandom_range(0, 3) == 0);
                ld_addr[s] = 8'($urandom_range(0, 15));
                ld_data[s] = $urandom;
                clr[s]     = ($urandom_range(0, 15) == 0);
                step();
            end
            rd[s] = 1'b0; ld_en[s] = 1'b0; clr[s] = 1'b0;
            repeat (6) step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
